conv_window_fetch: RTL and testbench
====================================

Name: conv_window_fetch

Overview:
Read-side sequencer directly downstream of the 16-bit data buffer (true dual-port BRAM, 13-bit address, 1-cycle read latency).
- Walks a row-major IMG_W x IMG_H feature map stored at BASE_ADDR.
- Issues read addresses and gathers each KxK stride-1 window into one packed word.
- Presents each window to the convolution engine through a valid/ready handshake.

Parameters:
DATA_WIDTH, 16, pixel width; matches buffer data port
ADDR_WIDTH, 13, buffer address width
K, 5, window edge; window holds K*K pixels
IMG_W, 28, map width in pixels
IMG_H, 28, map height in pixels
BASE_ADDR, 0, buffer address of pixel (0,0)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse that begins a full map scan
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse after the last window is accepted
rd_addr  out  ADDR_WIDTH  buffer read address
rd_data  in  DATA_WIDTH  buffer read data, valid 1 cycle after rd_addr
win_data  out  K*K*DATA_WIDTH  packed window; element e=ky*K+kx at bits [(e+1)*DATA_WIDTH-1 : e*DATA_WIDTH]
win_valid  out  1  win_data holds a complete window
win_ready  in  1  consumer accepts window when win_valid&&win_ready
win_row  out  8  output-row index of the presented window
win_col  out  8  output-col index of the presented window

Behaviour:
- Reset (asynchronous, any state): state=IDLE. busy, done, win_valid = 0. rd_addr, win_data, win_row, win_col and all counters = 0.
- Scan size: OUT_W=IMG_W-K+1, OUT_H=IMG_H-K+1. Windows are visited row-major: col fastest, then row.
- States:
  - IDLE: rd_addr=0. start=1 -> FETCH, with row=col=ky=kx=0 and busy=1 the next cycle.
  - FETCH: one address per cycle, rd_addr = BASE_ADDR + (row+ky)*IMG_W + (col+kx). kx increments first, then ky. Addresses come from running adders, not a multiplier in the loop. After issuing element K*K-1 -> LAST.
  - LAST: one cycle to capture the final rd_data -> PRESENT with win_valid=1.
  - PRESENT: win_data, win_row and win_col are held stable while win_valid=1 and win_ready=0. On handshake:
    - if this is not the final window: win_valid drops next cycle, col/row advance (col wraps at OUT_W, which increments row), ky=kx=0 -> FETCH.
    - if this is the final window (row=OUT_H-1, col=OUT_W-1) -> DONE.
  - DONE: done=1 and busy=0 for exactly one cycle -> IDLE.
- Capture pipeline: a registered copy of the element index, delayed 1 cycle, selects which win_data slot latches rd_data. The first element is captured in the cycle after the first FETCH cycle.
- Latency: start pulse to first win_valid = 1 + K*K + 1 cycles (27 for K=5). Handshake to next win_valid = K*K + 1 cycles. No pixel reuse between windows.
- rd_addr holds its last value in LAST, PRESENT and DONE; the buffer read is harmless there.
- start while busy=1 is ignored.
- start and reset together: reset wins.
- win_ready while win_valid=0 has no effect.
- Reset mid-scan aborts immediately. No done pulse; the next start begins at window (0,0).
- Width rules: address arithmetic is done at ADDR_WIDTH+1 bits, then truncated. The maximum address BASE_ADDR+IMG_W*IMG_H-1 must fit in ADDR_WIDTH; a violation is an elaboration-time error. win_row/win_col are zero-extended to 8 bits.

Test Plan:
1. K=3, IMG_W=IMG_H=6, BASE_ADDR=0, buffer model mem[a]=a, win_ready=1, start -> first window after 11 cycles. Elements 0..8 = {0,1,2,6,7,8,12,13,14}. win_row=win_col=0.
2. Same config, full scan -> exactly 16 handshakes. Last window = {21,22,23,27,28,29,33,34,35}, win_row=win_col=3. done pulses once, one cycle after the last handshake; busy falls with it.
3. Backpressure: hold win_ready=0 for 20 cycles on window (0,1) -> win_data {1,2,3,7,8,9,13,14,15} stays stable with no new rd_addr progress. Release -> next window (0,2) = {2,3,4,8,9,10,14,15,16}.
4. Pulse start again at cycles 5 and 40 of a running scan -> ignored. Window count is still 16 and done fires once.
5. Assert rst_n=0 mid-FETCH of window (2,1) -> all outputs 0 immediately. A new start yields window (0,0) = {0,1,2,6,7,8,12,13,14}.
6. Default K=5, 28x28, BASE_ADDR=100 -> first window element 0 = mem[100], element 24 = mem[216]. 576 windows total. rd_addr never exceeds 883.

Source files
------------

// File: rtl/conv_window_fetch.sv
// rtl/conv_window_fetch.sv - KxK stride-1 window read sequencer for the feature-map buffer
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle pulse that begins a full map scan (ignored while busy)
//   busy       scan in progress
//   done       one-cycle pulse after the final window is accepted
//   rd_addr    buffer read address (one address per FETCH cycle)
//   rd_data    buffer read data, valid one cycle after rd_addr
//   win_data   packed window, element ky*K+kx in slice [(e+1)*DATA_WIDTH-1 : e*DATA_WIDTH]
//   win_valid  win_data holds a complete window
//   win_ready  consumer accepts the window when win_valid && win_ready
//   win_row    output-row index of the presented window
//   win_col    output-col index of the presented window

module conv_window_fetch #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13,
    parameter int K          = 5,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int BASE_ADDR  = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [ADDR_WIDTH-1:0]       rd_addr,
    input  logic [DATA_WIDTH-1:0]       rd_data,
    output logic [K*K*DATA_WIDTH-1:0]   win_data,
    output logic                        win_valid,
    input  logic                        win_ready,
    output logic [7:0]                  win_row,
    output logic [7:0]                  win_col
);

    localparam int N     = K * K;
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam int CW    = (K > 1) ? $clog2(K) : 1;
    localparam int EW    = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0]  K_LAST    = CW'(K - 1);
    localparam logic [7:0]     COL_LAST  = 8'(OUT_W - 1);
    localparam logic [7:0]     ROW_LAST  = 8'(OUT_H - 1);
    localparam logic [AW1-1:0] BASE_A    = AW1'(BASE_ADDR);
    // kx wraps: jump from the window's right edge to the left edge one pixel row down
    localparam logic [AW1-1:0] LINE_STEP = AW1'(IMG_W - K + 1);
    // col wraps: jump from the last window of a row to column 0 of the next row
    localparam logic [AW1-1:0] WRAP_STEP = AW1'(K);
    localparam logic [AW1-1:0] ONE       = AW1'(1);

    if (BASE_ADDR + IMG_W * IMG_H - 1 > (1 << ADDR_WIDTH) - 1) begin : g_addr_check
        $error("conv_window_fetch: feature map does not fit in the buffer address space");
    end
    if (OUT_W > 256 || OUT_H > 256 || OUT_W < 1 || OUT_H < 1) begin : g_dim_check
        $error("conv_window_fetch: output map dimensions out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t         state;
    logic [CW-1:0]  kx;
    logic [CW-1:0]  ky;
    logic [EW-1:0]  elem;
    logic [EW-1:0]  cap_idx;
    logic           cap_en;
    logic [7:0]     row;
    logic [7:0]     col;
    logic [AW1-1:0] win_base;    // address of pixel (row, col): top-left of current window
    logic [AW1-1:0] fetch_addr;  // address currently on rd_addr, kept one bit wider
    logic [AW1-1:0] next_fetch;
    logic [AW1-1:0] next_base;

    always_comb begin
        next_fetch = fetch_addr + ((kx == K_LAST) ? LINE_STEP : ONE);
        next_base  = win_base + ((col == COL_LAST) ? WRAP_STEP : ONE);
    end

    assign rd_addr = fetch_addr[ADDR_WIDTH-1:0];
    assign win_row = row;
    assign win_col = col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            win_valid  <= 1'b0;
            win_data   <= '0;
            kx         <= '0;
            ky         <= '0;
            elem       <= '0;
            cap_idx    <= '0;
            cap_en     <= 1'b0;
            row        <= '0;
            col        <= '0;
            win_base   <= '0;
            fetch_addr <= '0;
        end else begin
            // rd_data answers the address issued one cycle earlier, so the
            // element index is delayed by one cycle to pick the slot to fill.
            cap_en  <= (state == S_FETCH);
            cap_idx <= elem;
            if (cap_en) begin
                for (int i = 0; i < N; i++) begin
                    if (cap_idx == EW'(i)) begin
                        win_data[i*DATA_WIDTH +: DATA_WIDTH] <= rd_data;
                    end
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_FETCH;
                        busy       <= 1'b1;
                        row        <= '0;
                        col        <= '0;
                        kx         <= '0;
                        ky         <= '0;
                        elem       <= '0;
                        win_base   <= BASE_A;
                        fetch_addr <= BASE_A;
                    end
                end

                S_FETCH: begin
                    if (kx == K_LAST && ky == K_LAST) begin
                        state <= S_LAST;
                    end else begin
                        elem       <= elem + EW'(1);
                        fetch_addr <= next_fetch;
                        if (kx == K_LAST) begin
                            kx <= '0;
                            ky <= ky + CW'(1);
                        end else begin
                            kx <= kx + CW'(1);
                        end
                    end
                end

                S_LAST: begin
                    state     <= S_PRESENT;
                    win_valid <= 1'b1;
                end

                S_PRESENT: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        if (row == ROW_LAST && col == COL_LAST) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state      <= S_FETCH;
                            kx         <= '0;
                            ky         <= '0;
                            elem       <= '0;
                            win_base   <= next_base;
                            fetch_addr <= next_base;
                            if (col == COL_LAST) begin
                                col <= '0;
                                row <= row + 8'd1;
                            end else begin
                                col <= col + 8'd1;
                            end
                        end
                    end
                end

                S_DONE: begin
                    state      <= S_IDLE;
                    done       <= 1'b0;
                    fetch_addr <= '0;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_fetch.sv
// tb/tb_conv_window_fetch.sv - self-checking bench for conv_window_fetch

module tb_conv_window_fetch;

    localparam int KS = 3, WS = 6, HS = 6, OWS = 4, OHS = 4;
    localparam int KB = 5, WB = 28, HB = 28, BB = 100, OWB = 24, OHB = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // small instance: K=3, 6x6, base 0, mem[a] = a
    logic                 rst_n_s, start_s, busy_s, done_s, win_valid_s, win_ready_s;
    logic [12:0]          rd_addr_s;
    logic [15:0]          rd_data_s;
    logic [KS*KS*16-1:0]  win_data_s;
    logic [7:0]           win_row_s, win_col_s;

    // big instance: K=5, 28x28, base 100, mem[a] = a*3+7
    logic                 rst_n_b, start_b, busy_b, done_b, win_valid_b, win_ready_b;
    logic [12:0]          rd_addr_b;
    logic [15:0]          rd_data_b;
    logic [KB*KB*16-1:0]  win_data_b;
    logic [7:0]           win_row_b, win_col_b;

    conv_window_fetch #(.DATA_WIDTH(16), .ADDR_WIDTH(13), .K(KS), .IMG_W(WS), .IMG_H(HS), .BASE_ADDR(0)) dut_s (
        .clk(clk), .rst_n(rst_n_s), .start(start_s), .busy(busy_s), .done(done_s),
        .rd_addr(rd_addr_s), .rd_data(rd_data_s), .win_data(win_data_s),
        .win_valid(win_valid_s), .win_ready(win_ready_s), .win_row(win_row_s), .win_col(win_col_s)
    );

    conv_window_fetch #(.DATA_WIDTH(16), .ADDR_WIDTH(13), .K(KB), .IMG_W(WB), .IMG_H(HB), .BASE_ADDR(BB)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .start(start_b), .busy(busy_b), .done(done_b),
        .rd_addr(rd_addr_b), .rd_data(rd_data_b), .win_data(win_data_b),
        .win_valid(win_valid_b), .win_ready(win_ready_b), .win_row(win_row_b), .win_col(win_col_b)
    );

    // buffers with one-cycle read latency
    always @(posedge clk) begin
        rd_data_s <= 16'(rd_addr_s);
        rd_data_b <= 16'({3'b000, rd_addr_b} * 16'd3 + 16'd7);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_w(input string name, input logic [399:0] act, input logic [399:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [143:0] pk9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
        return {16'(a8), 16'(a7), 16'(a6), 16'(a5), 16'(a4), 16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    // window n of a row-major scan, straight from the pixel coordinates
    function automatic logic [143:0] model_s(input int n);
        logic [143:0] w;
        int r, c, a;
        r = n / OWS;
        c = n % OWS;
        w = '0;
        for (int ky = 0; ky < KS; ky++)
            for (int kx = 0; kx < KS; kx++) begin
                a = (r + ky) * WS + c + kx;
                w[(ky*KS+kx)*16 +: 16] = 16'(a);
            end
        return w;
    endfunction

    function automatic logic [399:0] model_b(input int n);
        logic [399:0] w;
        int r, c, a;
        r = n / OWB;
        c = n % OWB;
        w = '0;
        for (int ky = 0; ky < KB; ky++)
            for (int kx = 0; kx < KB; kx++) begin
                a = BB + (r + ky) * WB + c + kx;
                w[(ky*KB+kx)*16 +: 16] = 16'(a * 3 + 7);
            end
        return w;
    endfunction

    // scoreboard: every presented window must match the n-th window of the scan
    int n_s = 0;
    int n_b = 0;
    always @(negedge clk) begin
        if (!rst_n_s) begin
            n_s = 0;
        end else begin
            if (win_valid_s) begin
                chk_w("sb_s_data", 400'(win_data_s), 400'(model_s(n_s)));
                chk("sb_s_row", int'(win_row_s), n_s / OWS);
                chk("sb_s_col", int'(win_col_s), n_s % OWS);
                if (win_ready_s) n_s++;
            end
            if (done_s) begin
                chk("sb_s_count_at_done", n_s, OWS * OHS);
                n_s = 0;
            end
        end
        if (!rst_n_b) begin
            n_b = 0;
        end else begin
            if (win_valid_b) begin
                chk_w("sb_b_data", 400'(win_data_b), model_b(n_b));
                chk("sb_b_row", int'(win_row_b), n_b / OWB);
                chk("sb_b_col", int'(win_col_b), n_b % OWB);
                if (win_ready_b) n_b++;
            end
            if (done_b) begin
                chk("sb_b_count_at_done", n_b, OWB * OHB);
                n_b = 0;
            end
        end
    end

    task automatic start_scan_s();
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
    endtask

    task automatic wait_valid_s(input int r, input int c, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (win_valid_s && int'(win_row_s) == r && int'(win_col_s) == c) seen = 1'b1;
        end
        chk(name, int'(seen), 1);
    endtask

    task automatic wait_done_s(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (done_s) seen = 1'b1;
        end
        chk(name, int'(seen), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, hs, dn, last_hs, done_seen, busy_at_done, maxa, mina;
        rst_n_s = 1'b0; start_s = 1'b0; win_ready_s = 1'b1;
        rst_n_b = 1'b0; start_b = 1'b0; win_ready_b = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy_s), 0);
        chk("rst_done", int'(done_s), 0);
        chk("rst_valid", int'(win_valid_s), 0);
        chk("rst_addr", int'(rd_addr_s), 0);
        chk_w("rst_data", 400'(win_data_s), 400'(0));
        chk("rst_row", int'(win_row_s), 0);
        chk("rst_col", int'(win_col_s), 0);
        chk("rst_b_addr", int'(rd_addr_b), 0);
        rst_n_s = 1'b1;
        rst_n_b = 1'b1;
        @(negedge clk);
        chk("idle_addr", int'(rd_addr_s), 0);
        chk("idle_busy", int'(busy_s), 0);

        // 1: first window latency and contents
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        chk("t1_busy_after_start", int'(busy_s), 1);
        lat = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (win_valid_s) break;
            lat++;
        end
        chk("t1_latency", lat, 11);
        chk_w("t1_window00", 400'(win_data_s), 400'(pk9(0, 1, 2, 6, 7, 8, 12, 13, 14)));
        chk("t1_row", int'(win_row_s), 0);
        chk("t1_col", int'(win_col_s), 0);

        // 2: full scan, last window, done timing
        hs = 0; last_hs = -10; done_seen = -1; busy_at_done = -1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (done_s) begin
                done_seen = cyc;
                busy_at_done = int'(busy_s);
                break;
            end
            if (win_valid_s && win_ready_s) begin
                hs++;
                if (win_row_s == 8'd3 && win_col_s == 8'd3) begin
                    last_hs = cyc;
                    chk_w("t2_last_window", 400'(win_data_s), 400'(pk9(21, 22, 23, 27, 28, 29, 33, 34, 35)));
                end
            end
        end
        chk("t2_handshakes", hs, 16);
        chk("t2_done_after_last_hs", done_seen, last_hs + 1);
        chk("t2_busy_at_done", busy_at_done, 0);
        @(negedge clk);
        chk("t2_done_one_pulse", int'(done_s), 0);

        // 3: backpressure on window (0,1)
        start_scan_s();
        wait_valid_s(0, 0, "t3_reach_00");
        @(posedge clk); #1 win_ready_s = 1'b0;
        wait_valid_s(0, 1, "t3_reach_01");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk_w("t3_stall_data", 400'(win_data_s), 400'(pk9(1, 2, 3, 7, 8, 9, 13, 14, 15)));
            chk("t3_stall_valid", int'(win_valid_s), 1);
            chk("t3_stall_addr", int'(rd_addr_s), 15);
        end
        @(posedge clk); #1 win_ready_s = 1'b1;
        wait_valid_s(0, 2, "t3_reach_02");
        chk_w("t3_window02", 400'(win_data_s), 400'(pk9(2, 3, 4, 8, 9, 10, 14, 15, 16)));
        wait_done_s("t3_done");

        // 4: start pulses during a running scan are ignored
        start_scan_s();
        hs = 0; dn = 0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(posedge clk); #1 start_s = (cyc == 5 || cyc == 40);
            @(negedge clk);
            if (win_valid_s && win_ready_s) hs++;
            if (done_s) dn++;
        end
        chk("t4_handshakes", hs, 16);
        chk("t4_done_count", dn, 1);
        chk("t4_busy_end", int'(busy_s), 0);

        // 5: reset in the middle of fetching window (2,1)
        start_scan_s();
        wait_valid_s(2, 0, "t5_reach_20");
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 rst_n_s = 1'b0;
        #1;
        chk("t5_busy", int'(busy_s), 0);
        chk("t5_done", int'(done_s), 0);
        chk("t5_valid", int'(win_valid_s), 0);
        chk("t5_addr", int'(rd_addr_s), 0);
        chk_w("t5_data", 400'(win_data_s), 400'(0));
        chk("t5_row", int'(win_row_s), 0);
        chk("t5_col", int'(win_col_s), 0);
        @(posedge clk); #1 rst_n_s = 1'b1;
        start_scan_s();
        wait_valid_s(0, 0, "t5_restart_00");
        chk_w("t5_window00", 400'(win_data_s), 400'(pk9(0, 1, 2, 6, 7, 8, 12, 13, 14)));
        wait_done_s("t5_done_after_restart");

        // 6: default geometry, base 100, with periodic backpressure
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        maxa = int'(rd_addr_b);
        mina = int'(rd_addr_b);
        lat = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (int'(rd_addr_b) > maxa) maxa = int'(rd_addr_b);
            if (int'(rd_addr_b) < mina) mina = int'(rd_addr_b);
            if (win_valid_b) break;
            lat++;
        end
        chk("t6_latency", lat, 27);
        chk("t6_elem0", int'(win_data_b[15:0]), 307);
        chk("t6_elem24", int'(win_data_b[24*16 +: 16]), 655);
        hs = (win_valid_b && win_ready_b) ? 1 : 0;
        done_seen = 0;
        for (int cyc = 0; cyc < 40000; cyc++) begin
            @(posedge clk); #1 win_ready_b = (cyc % 3 != 2);
            @(negedge clk);
            if (busy_b) begin
                if (int'(rd_addr_b) > maxa) maxa = int'(rd_addr_b);
                if (int'(rd_addr_b) < mina) mina = int'(rd_addr_b);
            end
            if (win_valid_b && win_ready_b) hs++;
            if (done_b) begin
                done_seen = 1;
                break;
            end
        end
        chk("t6_done", done_seen, 1);
        chk("t6_handshakes", hs, 576);
        chk("t6_max_addr", maxa, 883);
        chk("t6_min_addr", mina, 100);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
